// File: rtl/mem_bus_arbiter.sv
// Arbitrates one SRAM-like memory port between instruction fetch and data requesters.
// Data has priority; a streak counter forces a fetch grant after MAX_D_STREAK data grants.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int unsigned STREAK_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

  state_t              state, state_next;
  owner_t              owner, owner_next;
  logic [STREAK_W-1:0] streak, streak_next;
  logic                lat_wr, lat_wr_next;
  logic [1:0]          lat_size, lat_size_next;
  logic [ADDR_W-1:0]   lat_addr, lat_addr_next;
  logic [DATA_W-1:0]   lat_wdata, lat_wdata_next;
  logic                grant_i, grant_d;

  // State and latched-request registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      owner     <= OWN_NONE;
      streak    <= '0;
      lat_wr    <= 1'b0;
      lat_size  <= 2'd0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state     <= state_next;
      owner     <= owner_next;
      streak    <= streak_next;
      lat_wr    <= lat_wr_next;
      lat_size  <= lat_size_next;
      lat_addr  <= lat_addr_next;
      lat_wdata <= lat_wdata_next;
    end
  end

  // Grant, next-state and handshake outputs
  always_comb begin
    state_next     = state;
    owner_next     = owner;
    streak_next    = streak;
    lat_wr_next    = lat_wr;
    lat_size_next  = lat_size;
    lat_addr_next  = lat_addr;
    lat_wdata_next = lat_wdata;
    grant_i        = 1'b0;
    grant_d        = 1'b0;
    i_addr_ok      = 1'b0;
    d_addr_ok      = 1'b0;
    i_data_ok      = 1'b0;
    d_data_ok      = 1'b0;

    case (state)
      S_IDLE: begin
        if (d_req && !(i_req && streak == STREAK_MAX)) begin
          grant_d = 1'b1;
        end else if (i_req) begin
          grant_i = 1'b1;
        end
        if (grant_d) begin
          lat_wr_next    = d_wr;
          lat_size_next  = d_size;
          lat_addr_next  = d_addr;
          lat_wdata_next = d_wdata;
          owner_next     = OWN_D;
          state_next     = S_ADDR;
        end else if (grant_i) begin
          lat_wr_next    = 1'b0;
          lat_size_next  = 2'd2;
          lat_addr_next  = i_addr;
          lat_wdata_next = '0;
          owner_next     = OWN_I;
          state_next     = S_ADDR;
        end
      end
      S_ADDR: begin
        if (m_addr_ok) state_next = S_WAIT;
      end
      S_WAIT: begin
        i_data_ok = m_data_ok && (owner == OWN_I);
        d_data_ok = m_data_ok && (owner == OWN_D);
        if (m_data_ok) begin
          state_next = S_IDLE;
          owner_next = OWN_NONE;
        end
      end
      default: begin
        state_next = S_IDLE;
        owner_next = OWN_NONE;
      end
    endcase

    // Handshakes are suppressed while reset is asserted
    i_addr_ok = grant_i && resetn;
    d_addr_ok = grant_d && resetn;
    i_data_ok = i_data_ok && resetn;
    d_data_ok = d_data_ok && resetn;

    if (!i_req || grant_i) begin
      streak_next = '0;
    end else if (grant_d && streak != STREAK_MAX) begin
      streak_next = streak + STREAK_W'(1);
    end
  end

  assign m_req   = (state == S_ADDR);
  assign m_wr    = lat_wr;
  assign m_size  = lat_size;
  assign m_addr  = lat_addr;
  assign m_wdata = lat_wdata;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vectors, corner sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int unsigned MAXS = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_req, d_req, d_wr;
  logic [1:0]  d_size;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic [31:0] i_rdata, d_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
    .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        i_req, d_req, d_wr;
    logic [1:0]  d_size;
    logic [31:0] i_addr, d_addr, d_wdata, rdata;
    logic        exp_i, exp_d, exp_wr;
    logic [1:0]  exp_size;
    logic [31:0] exp_addr, exp_wdata;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req = 0; d_req = 0; d_wr = 0; d_size = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
  endtask

  // Leaves the bench one cycle after a one-cycle reset, in the drive slot
  task automatic do_reset();
    drive_slot();
    resetn = 0;
    clear_inputs();
    drive_slot();
    resetn = 1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    do_reset();
    i_req = v.i_req; d_req = v.d_req; d_wr = v.d_wr; d_size = v.d_size;
    i_addr = v.i_addr; d_addr = v.d_addr; d_wdata = v.d_wdata;
    @(negedge clk);
    check({tag, "_i_addr_ok"}, 64'(i_addr_ok), 64'(v.exp_i));
    check({tag, "_d_addr_ok"}, 64'(d_addr_ok), 64'(v.exp_d));
    check({tag, "_m_req_c0"}, 64'(m_req), 64'(0));
    drive_slot();
    i_req = 0; d_req = 0; m_addr_ok = 1;
    @(negedge clk);
    if (v.exp_i || v.exp_d) begin
      check({tag, "_m_req_c1"}, 64'(m_req), 64'(1));
      check({tag, "_m_wr"}, 64'(m_wr), 64'(v.exp_wr));
      check({tag, "_m_size"}, 64'(m_size), 64'(v.exp_size));
      check({tag, "_m_addr"}, 64'(m_addr), 64'(v.exp_addr));
      check({tag, "_m_wdata"}, 64'(m_wdata), 64'(v.exp_wdata));
    end else begin
      check({tag, "_m_req_idle"}, 64'(m_req), 64'(0));
    end
    drive_slot();
    m_addr_ok = 0; m_data_ok = 1; m_rdata = v.rdata;
    @(negedge clk);
    check({tag, "_i_data_ok"}, 64'(i_data_ok), 64'(v.exp_i));
    check({tag, "_d_data_ok"}, 64'(d_data_ok), 64'(v.exp_d));
    if (v.exp_i) check({tag, "_i_rdata"}, 64'(i_rdata), 64'(v.rdata));
    if (v.exp_d) check({tag, "_d_rdata"}, 64'(d_rdata), 64'(v.rdata));
    drive_slot();
    m_data_ok = 0;
  endtask

  // Reference-model state for the randomized run
  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    bit          is_d;
  } txn_t;

  initial begin
    int   gc[$];
    byte  gt[$];
    byte  exp_order[6];
    int   phase, streak;
    txn_t cur;
    bit   i_got, d_got, eg_i, eg_d;

    vecs[0] = '{1, 0, 0, 2'd0, 32'hBFC00000, 32'h0, 32'h0, 32'h3C08BFAF,
                1, 0, 0, 2'd2, 32'hBFC00000, 32'h0};
    vecs[1] = '{0, 1, 1, 2'd0, 32'h0, 32'h80001003, 32'h000000AA, 32'h0,
                0, 1, 1, 2'd0, 32'h80001003, 32'h000000AA};
    vecs[2] = '{1, 1, 0, 2'd2, 32'hBFC00010, 32'h80002000, 32'h0, 32'h12345678,
                0, 1, 0, 2'd2, 32'h80002000, 32'h0};
    vecs[3] = '{0, 0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0,
                0, 0, 0, 2'd0, 32'h0, 32'h0};
    vecs[4] = '{0, 1, 1, 2'd1, 32'h0, 32'h80000002, 32'h0000BEEF, 32'hDEADBEEF,
                0, 1, 1, 2'd1, 32'h80000002, 32'h0000BEEF};

    // Reset state, with requests pending during reset
    resetn = 0;
    clear_inputs();
    i_req = 1; d_req = 1; i_addr = 32'h1234; d_addr = 32'h5678; d_wdata = 32'h9;
    m_data_ok = 1;
    drive_slot();
    drive_slot();
    @(negedge clk);
    check("rst_i_addr_ok", 64'(i_addr_ok), 64'(0));
    check("rst_d_addr_ok", 64'(d_addr_ok), 64'(0));
    check("rst_data_ok", 64'({i_data_ok, d_data_ok}), 64'(0));
    check("rst_m_bus", {m_req, m_wr, m_size, m_addr, m_wdata[27:0]}, 64'(0));

    for (int k = 0; k < 5; k++) run_vec(vecs[k], k);

    // Starvation guard: both held high, zero-wait memory
    exp_order = '{"D", "D", "D", "D", "I", "D"};
    do_reset();
    i_req = 1; d_req = 1; i_addr = 32'hBFC00100; d_addr = 32'h80004000;
    m_addr_ok = 1; m_data_ok = 1;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (d_addr_ok) begin gc.push_back(c); gt.push_back("D"); end
      if (i_addr_ok) begin gc.push_back(c); gt.push_back("I"); end
      drive_slot();
    end
    check("starve_count", 64'(gc.size()), 64'(6));
    for (int k = 0; k < 6 && k < gc.size(); k++) begin
      check($sformatf("starve_type%0d", k), 64'(gt[k]), 64'(exp_order[k]));
      check($sformatf("starve_cycle%0d", k), 64'(gc[k]), 64'(3 * k));
    end
    clear_inputs();

    // Back-pressure: m_addr_ok low for three cycles
    do_reset();
    d_req = 1; d_wr = 1; d_size = 2'd2; d_addr = 32'h80003000; d_wdata = 32'hCAFEF00D;
    @(negedge clk);
    check("bp_d_addr_ok", 64'(d_addr_ok), 64'(1));
    for (int c = 1; c <= 4; c++) begin
      drive_slot();
      d_req = 0; d_addr = 32'hFFFFFFFF; d_wdata = 32'h0;
      m_addr_ok = (c == 4);
      m_data_ok = (c == 2);
      @(negedge clk);
      check($sformatf("bp_m_req%0d", c), 64'(m_req), 64'(1));
      check($sformatf("bp_m_addr%0d", c), 64'(m_addr), 64'(32'h80003000));
      check($sformatf("bp_m_wdata%0d", c), 64'(m_wdata), 64'(32'hCAFEF00D));
      check($sformatf("bp_early_ok%0d", c), 64'(d_data_ok), 64'(0));
    end
    drive_slot();
    m_addr_ok = 0; m_data_ok = 1;
    @(negedge clk);
    check("bp_wait_m_req", 64'(m_req), 64'(0));
    check("bp_d_data_ok", 64'(d_data_ok), 64'(1));
    drive_slot();
    m_data_ok = 0;

    // Reset while in WAIT, late m_data_ok must be ignored
    do_reset();
    i_req = 1; i_addr = 32'hBFC00200;
    @(negedge clk);
    check("rw_i_addr_ok", 64'(i_addr_ok), 64'(1));
    drive_slot();
    i_req = 0; m_addr_ok = 1;
    @(negedge clk);
    check("rw_m_req", 64'(m_req), 64'(1));
    drive_slot();
    m_addr_ok = 0; m_data_ok = 1; resetn = 0;
    @(negedge clk);
    check("rw_data_ok_in_rst", 64'({i_data_ok, d_data_ok}), 64'(0));
    drive_slot();
    resetn = 1; m_data_ok = 1;
    @(negedge clk);
    check("rw_after_m_req", 64'(m_req), 64'(0));
    check("rw_after_data_ok", 64'({i_data_ok, d_data_ok}), 64'(0));
    drive_slot();
    m_data_ok = 0; d_req = 1; d_wr = 0; d_size = 2'd2; d_addr = 32'h80005000;
    @(negedge clk);
    check("rw_new_grant", 64'(d_addr_ok), 64'(1));
    drive_slot();
    d_req = 0; m_addr_ok = 1;
    @(negedge clk);
    check("rw_new_m_addr", 64'({m_req, m_addr}), {31'd0, 1'b1, 32'h80005000});
    drive_slot();
    m_addr_ok = 0; m_data_ok = 1;
    @(negedge clk);
    check("rw_new_d_data_ok", 64'(d_data_ok), 64'(1));

    // Randomized run against a transaction-level model
    do_reset();
    phase = 0; streak = 0; i_got = 0; d_got = 0;
    cur = '{0, 2'd0, 32'h0, 32'h0, 0};
    for (int c = 0; c < 3000; c++) begin
      if (i_got) i_req = 0;
      else if (!i_req && $urandom_range(0, 1) == 0) begin
        i_req = 1; i_addr = $urandom;
      end
      if (d_got) d_req = 0;
      else if (!d_req && $urandom_range(0, 1) == 0) begin
        d_req = 1; d_wr = 1'($urandom_range(0, 1)); d_size = 2'($urandom_range(0, 2));
        d_addr = $urandom; d_wdata = $urandom;
      end
      m_addr_ok = 1'($urandom_range(0, 1));
      m_data_ok = 1'($urandom_range(0, 1));
      m_rdata = $urandom;
      @(negedge clk);
      eg_d = (phase == 0) && d_req && !(i_req && streak == MAXS);
      eg_i = (phase == 0) && !eg_d && i_req;
      check("rnd_i_addr_ok", 64'(i_addr_ok), 64'(eg_i));
      check("rnd_d_addr_ok", 64'(d_addr_ok), 64'(eg_d));
      check("rnd_m_req", 64'(m_req), 64'(phase == 1));
      if (phase == 1)
        check("rnd_m_fields", {m_wr, m_size, m_addr, m_wdata[28:0]},
              {cur.wr, cur.size, cur.addr, cur.wdata[28:0]});
      check("rnd_i_data_ok", 64'(i_data_ok), 64'(phase == 2 && m_data_ok && !cur.is_d));
      check("rnd_d_data_ok", 64'(d_data_ok), 64'(phase == 2 && m_data_ok && cur.is_d));
      if (phase == 2 && m_data_ok)
        check("rnd_rdata", 64'(cur.is_d ? d_rdata : i_rdata), 64'(m_rdata));
      i_got = eg_i; d_got = eg_d;
      if (eg_d) cur = '{d_wr, d_size, d_addr, d_wdata, 1};
      if (eg_i) cur = '{0, 2'd2, i_addr, 32'h0, 0};
      if (!i_req || eg_i) streak = 0;
      else if (eg_d) streak = (streak + 1 > MAXS) ? MAXS : streak + 1;
      if (phase == 0 && (eg_d || eg_i)) phase = 1;
      else if (phase == 1 && m_addr_ok) phase = 2;
      else if (phase == 2 && m_data_ok) phase = 0;
      drive_slot();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester (i_*) and the data requester (d_*).
- Sits between the pipeline's fetch/memory stages and the cache/bus bridge.
- Allows one outstanding transaction at a time. Data has priority; a streak counter guarantees fetch forward progress.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_D_STREAK, 4, max consecutive data grants while i_req is pending before fetch is forced; minimum 1.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- i_req  in  1  fetch request (read only).
- i_addr  in  ADDR_W  fetch address.
- i_addr_ok  out  1  fetch request accepted.
- i_data_ok  out  1  fetch data valid.
- i_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data request.
- d_wr  in  1  1 = write.
- d_size  in  2  0 = byte, 1 = half, 2 = word.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_addr_ok  out  1  data request accepted.
- d_data_ok  out  1  data read/write done.
- d_rdata  out  DATA_W  data read data.
- m_req  out  1  shared port request.
- m_wr  out  1  shared port write.
- m_size  out  2  shared port size.
- m_addr  out  ADDR_W  shared port address.
- m_wdata  out  DATA_W  shared port write data.
- m_addr_ok  in  1  shared port accepted request.
- m_data_ok  in  1  shared port data/completion.
- m_rdata  in  DATA_W  shared port read data.

Behaviour:
- Clock/reset: single clock clk; synchronous active-low reset resetn. When resetn=0 at a clk edge:
  - state=IDLE; owner=NONE; streak=0.
  - All latched request registers are 0, so m_req, m_wr, m_size, m_addr, m_wdata are 0.
  - i_addr_ok, d_addr_ok, i_data_ok, d_data_ok are 0 during and after reset until a grant.
- States:
  - IDLE: no transaction.
  - ADDR: m_req held, waiting for m_addr_ok.
  - WAIT: request accepted, waiting for m_data_ok.
- Grant (IDLE only, combinational):
  - Grant data if d_req && !(i_req && streak==MAX_D_STREAK).
  - Otherwise grant fetch if i_req.
  - The granted x_addr_ok=1 in that same cycle; it is 0 in every other cycle.
  - On the clock edge, the granted request's wr/size/addr/wdata are latched. A fetch latches wr=0, size=2. Then owner=winner and state=ADDR.
- Streak counter:
  - Data grant while i_req=1: streak+1, saturating at MAX_D_STREAK.
  - Fetch grant, or any cycle with i_req=0: streak=0.
- ADDR state:
  - m_req=1; m_wr/m_size/m_addr/m_wdata come from the latched registers and stay stable until m_addr_ok.
  - On m_addr_ok: state=WAIT.
  - m_req is 0 in IDLE and WAIT.
- WAIT state:
  - owner's x_data_ok = m_data_ok (combinational); the other requester's data_ok=0.
  - On m_data_ok: state=IDLE, owner=NONE. The next grant is possible the following cycle.
- m_data_ok outside WAIT is ignored: no data_ok, no state change.
- i_rdata = d_rdata = m_rdata (combinational copy); valid only with the matching data_ok.
- Minimum latency with zero-wait memory:
  - cycle 0: req/addr_ok.
  - cycle 1: m_req with m_addr_ok.
  - cycle 2: m_data_ok → x_data_ok.
  - cycle 3: next grant.
- Requesters must drop or change their request only after x_addr_ok. A request deasserted before grant is simply not served.
- Reset during ADDR or WAIT:
  - Transaction abandoned; next cycle is IDLE with m_req=0.
  - Any later m_data_ok is ignored per the rule above.
- Simultaneous i_req and d_req with streak<MAX_D_STREAK: data wins.

Test Plan:
- Fetch only: i_req=1, i_addr=0xBFC00000, zero-wait memory, m_rdata=0x3C08BFAF.
  - i_addr_ok at cycle 0; m_req=1, m_addr=0xBFC00000, m_wr=0, m_size=2 at cycle 1; i_data_ok=1, i_rdata=0x3C08BFAF at cycle 2; d_addr_ok/d_data_ok stay 0.
- Data byte write: d_req=1, d_wr=1, d_size=0, d_addr=0x80001003, d_wdata=0x000000AA.
  - m_wr=1, m_size=0, m_addr=0x80001003, m_wdata=0xAA at cycle 1; d_data_ok pulse on m_data_ok.
- Both requesting in the same cycle with streak=0: data granted first, fetch granted in the cycle after d_data_ok; streak=1 after the data grant.
- Starvation guard: d_req and i_req held high continuously.
  - Grant order: D,D,D,D,I,D,…; streak returns to 0 after the fetch grant.
- Back-pressure: m_addr_ok held low for 3 cycles after m_req rises.
  - m_req stays 1 and m_addr/m_wdata stay unchanged for 4 cycles; state moves to WAIT only on the edge where m_addr_ok=1.
- Reset mid-WAIT: resetn=0 for 1 cycle while in WAIT, then m_data_ok=1 arrives after reset.
  - state=IDLE, m_req=0, no i_data_ok/d_data_ok; a new request is granted normally afterwards.
